// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: state codes, light
// encodings and a small helper used to size the phase counter.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    PED_WALK  = 3'd6,
    EMERG     = 3'd7
  } phase_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  // Lamp encoding is {R,Y,G}, one-hot.
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that measures phase length in timebase ticks.
// It stops at zero instead of wrapping and can be frozen.
module phase_timer #(
  parameter int             W         = 5,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         freeze,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (tick && !freeze && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-direction intersection phase controller with pedestrian walk insertion
// and an emergency all-red override; phase timing comes from phase_timer.
module traffic_phase_ctrl #(
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);
  import traffic_pkg::*;

  localparam int CW = $clog2(max_of4(T_GREEN, T_YELLOW, T_ALLRED, T_PED) + 1);

  localparam logic [CW-1:0] LD_GREEN  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] LD_YELLOW = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] LD_ALLRED = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LD_PED    = CW'(T_PED - 1);

  phase_t          state, state_n;
  dir_t            next_green;
  logic [CW-1:0]   remain;
  logic [CW-1:0]   load_val;
  logic            load;
  logic            t_zero;
  logic            expire;
  logic            ped_q;
  logic            ped_pending;
  logic            ped_edge;
  logic            enter_ped;

  phase_timer #(
    .W         (CW),
    .RESET_VAL (LD_ALLRED)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .freeze   (state == EMERG),
    .value    (remain),
    .zero     (t_zero)
  );

  assign expire    = tick && t_zero;
  assign ped_edge  = ped_req && !ped_q;
  assign enter_ped = (state_n == PED_WALK) && (state != PED_WALK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ALL_RED2;
    end else begin
      state <= state_n;
    end
  end

  // Emergency is checked before expiry everywhere except yellow, which always
  // runs its full clearance before the override takes effect.
  always_comb begin
    state_n = state;
    case (state)
      NS_GREEN:  if (emergency || expire) state_n = NS_YELLOW;
      NS_YELLOW: if (expire) state_n = emergency ? EMERG : ALL_RED1;
      ALL_RED1: begin
        if (emergency)   state_n = EMERG;
        else if (expire) state_n = ped_pending ? PED_WALK : EW_GREEN;
      end
      EW_GREEN:  if (emergency || expire) state_n = EW_YELLOW;
      EW_YELLOW: if (expire) state_n = emergency ? EMERG : ALL_RED2;
      ALL_RED2: begin
        if (emergency)   state_n = EMERG;
        else if (expire) state_n = ped_pending ? PED_WALK : NS_GREEN;
      end
      PED_WALK: begin
        if (emergency)   state_n = EMERG;
        else if (expire) state_n = (next_green == DIR_NS) ? NS_GREEN : EW_GREEN;
      end
      EMERG:     if (!emergency) state_n = ALL_RED2;
      default:   state_n = ALL_RED2;
    endcase
  end

  // Every state change restarts the timer with the full length of the new state.
  always_comb begin
    load     = (state_n != state);
    load_val = '0;
    case (state_n)
      NS_GREEN, EW_GREEN:   load_val = LD_GREEN;
      NS_YELLOW, EW_YELLOW: load_val = LD_YELLOW;
      ALL_RED1, ALL_RED2:   load_val = LD_ALLRED;
      PED_WALK:             load_val = LD_PED;
      default:              load_val = '0;
    endcase
  end

  // Pedestrian request/acknowledge: a rising edge of ped_req is held as a
  // pending request; ped_ack is a single-cycle pulse in the first cycle of the
  // walk that serves it, and edges seen while entering or inside the walk are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_q       <= 1'b0;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
      next_green  <= DIR_NS;
    end else begin
      ped_q   <= ped_req;
      ped_ack <= enter_ped;
      if (enter_ped) begin
        ped_pending <= 1'b0;
        next_green  <= (state == ALL_RED1) ? DIR_EW : DIR_NS;
      end else if (ped_edge && (state != PED_WALK)) begin
        ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    walk     = 1'b0;
    case (state)
      NS_GREEN:  ns_light = GREEN;
      NS_YELLOW: ns_light = YELLOW;
      EW_GREEN:  ew_light = GREEN;
      EW_YELLOW: ew_light = YELLOW;
      PED_WALK:  walk     = 1'b1;
      default:   ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: expected phase entries (lights, walk,
// ack and tick duration) are queued by the stimulus and checked by a monitor.
module tb_traffic_phase_ctrl;

  localparam int EXP_W = 15;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       tick      = 1'b0;
  logic       ped_req   = 1'b0;
  logic       emergency = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  // Entry layout: [14:11] ticks spent in phase (0 = unchecked), [10] ack,
  // [9] walk, [8:6] ew, [5:3] ns, [2:0] phase.
  logic [EXP_W-1:0] exp_q[$];

  traffic_phase_ctrl #(
    .T_GREEN  (3),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .T_PED    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .ped_req   (ped_req),
    .emergency (emergency),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .walk      (walk),
    .ped_ack   (ped_ack),
    .phase     (phase)
  );

  // clock / reset / timebase
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  function automatic logic [EXP_W-1:0] mk(input logic [2:0] ph, input logic [3:0] dur,
                                          input logic ack);
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    ns = 3'b100;
    ew = 3'b100;
    wk = 1'b0;
    case (ph)
      3'd0: ns = 3'b001;
      3'd1: ns = 3'b010;
      3'd3: ew = 3'b001;
      3'd4: ew = 3'b010;
      3'd6: wk = 1'b1;
      default: ;
    endcase
    return {dur, ack, wk, ew, ns, ph};
  endfunction

  task automatic push(input logic [2:0] ph, input logic [3:0] dur, input logic ack);
    exp_q.push_back(mk(ph, dur, ack));
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_%s got %0d entries left want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_phase(input logic [2:0] p, input string tag);
    int n;
    n = 0;
    while (phase !== p && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (phase !== p) begin
      errors++;
      $display("FAIL timeout_%s got phase %0d want %0d", tag, phase, p);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [EXP_W-1:0] cur;
    logic [EXP_W-1:0] got;
    logic [2:0]       prev_phase;
    logic             have_prev;
    int               tick_cnt;
    cur        = '0;
    prev_phase = 3'd0;
    have_prev  = 1'b0;
    tick_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!have_prev || phase !== prev_phase) begin
        if (have_prev && cur[14:11] != 4'd0) begin
          checks++;
          if (tick_cnt != int'(cur[14:11])) begin
            errors++;
            $display("FAIL dur_phase%0d got %0d ticks want %0d", prev_phase, tick_cnt, cur[14:11]);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_phase got %0d want no change", phase);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
          got = {cur[14:11], ped_ack, walk, ew_light, ns_light, phase};
          if (got[10:0] !== cur[10:0]) begin
            errors++;
            $display("FAIL entry got ph=%0d ns=%b ew=%b walk=%b ack=%b want ph=%0d ns=%b ew=%b walk=%b ack=%b",
                     got[2:0], got[5:3], got[8:6], got[9], got[10],
                     cur[2:0], cur[5:3], cur[8:6], cur[9], cur[10]);
          end
        end
        tick_cnt   = 0;
        prev_phase = phase;
        have_prev  = 1'b1;
      end else begin
        checks++;
        if (ped_ack !== 1'b0) begin
          errors++;
          $display("FAIL ped_ack_extra got %b in phase %0d want 0", ped_ack, phase);
        end
      end
      if (tick && !reset) tick_cnt++;
    end
  end

  // stimulus
  initial begin
    push(3'd5, 4'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    // plain cycle after reset
    push(3'd0, 4'd3, 1'b0); push(3'd1, 4'd2, 1'b0); push(3'd2, 4'd1, 1'b0);
    push(3'd3, 4'd3, 1'b0); push(3'd4, 4'd2, 1'b0); push(3'd5, 4'd1, 1'b0);
    push(3'd0, 4'd3, 1'b0);
    reset = 1'b0;
    wait_drain("normal");

    // single request during NS green, served after ALL_RED1, then EW green
    push(3'd1, 4'd2, 1'b0); push(3'd2, 4'd1, 1'b0); push(3'd6, 4'd2, 1'b1);
    push(3'd3, 4'd3, 1'b0); push(3'd4, 4'd2, 1'b0); push(3'd5, 4'd1, 1'b0);
    push(3'd0, 4'd3, 1'b0);
    ped_req = 1'b1;
    @(posedge clk); #1;
    ped_req = 1'b0;
    wait_drain("ped_single");

    // three edges in one green collapse into one walk
    push(3'd1, 4'd2, 1'b0); push(3'd2, 4'd1, 1'b0); push(3'd6, 4'd2, 1'b1);
    push(3'd3, 4'd3, 1'b0); push(3'd4, 4'd2, 1'b0); push(3'd5, 4'd1, 1'b0);
    push(3'd0, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ped_req = 1'b1;
      @(posedge clk); #1;
      ped_req = 1'b0;
      @(posedge clk); #1;
    end
    wait_drain("ped_triple");

    // emergency mid EW green: cut green after one tick, yellow, hold, recover
    push(3'd1, 4'd2, 1'b0); push(3'd2, 4'd1, 1'b0); push(3'd3, 4'd1, 1'b0);
    wait_drain("to_ew");
    push(3'd4, 4'd2, 1'b0); push(3'd7, 4'd0, 1'b0); push(3'd5, 4'd1, 1'b0);
    push(3'd0, 4'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    emergency = 1'b1;
    wait_phase(3'd7, "emerg");
    repeat (40) @(posedge clk);
    #1;
    emergency = 1'b0;
    wait_drain("emerg_release");

    // emergency coinciding with the expiring tick of NS green, plus a request
    push(3'd1, 4'd2, 1'b0); push(3'd2, 4'd1, 1'b0); push(3'd6, 4'd0, 1'b1);
    @(posedge clk); #1;
    ped_req = 1'b1;
    @(posedge clk); #1;
    ped_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    emergency = 1'b1;
    @(posedge clk); #1;
    emergency = 1'b0;
    wait_drain("tick_emerg");

    // reset in the middle of the walk
    @(posedge clk); #1;
    push(3'd5, 4'd1, 1'b0);
    reset = 1'b1;
    #1;
    chk("reset_phase", {5'd0, phase}, 8'd5);
    chk("reset_ns", {5'd0, ns_light}, 8'h04);
    chk("reset_ew", {5'd0, ew_light}, 8'h04);
    chk("reset_walk", {7'd0, walk}, 8'd0);
    chk("reset_ack", {7'd0, ped_ack}, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    push(3'd0, 4'd3, 1'b0); push(3'd1, 4'd2, 1'b0); push(3'd2, 4'd1, 1'b0);
    push(3'd3, 4'd0, 1'b0);
    reset = 1'b0;
    wait_drain("after_reset");
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
